// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / bubble / flush sequencing for the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers plus the PC write enable.
// Handles load-use stalls, EX-stage branch redirects (multi-cycle flush) and
// data-memory busy freezes. Optional perf counters under `STALL_CNT_EN`.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W        = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             br_redirect,
  input  logic             dmem_busy,
  output logic             pc_write_en,
  output logic             pc_sel_redir,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_MWAIT = 2'd3
  } state_t;

  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_fcnt;
  logic [2:0] w_next_fcnt;
  logic       w_load_use;
  logic       w_redir;
  logic       w_redir_taken;

  assign w_load_use = id_valid & ex_valid & ex_mem_read &
                      ((id_use1 & (ex_dest == id_src1)) |
                       (id_use2 & (ex_dest == id_src2)));
  assign w_redir    = br_redirect & ex_valid;

  // State and flush-counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_fcnt  <= w_next_fcnt;
    end
  end

  // Next-state and pipeline-control outputs; priority busy > redirect > load-use
  always_comb begin
    pc_write_en    = 1'b0;
    pc_sel_redir   = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    id_ex_hold     = 1'b0;
    ex_mem_hold    = 1'b0;
    mem_wb_bubble  = 1'b0;
    w_next_state   = r_state;
    w_next_fcnt    = r_fcnt;
    w_redir_taken  = 1'b0;
    case (r_state)
      S_RUN, S_FLUSH, S_MWAIT: begin
        if (dmem_busy) begin
          // freeze everything; fcnt is kept so an interrupted flush resumes
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          w_next_state  = S_MWAIT;
        end else if (w_redir) begin
          pc_sel_redir   = 1'b1;
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_bubble   = 1'b1;
          w_redir_taken  = 1'b1;
          w_next_fcnt    = FCNT_RELOAD;
          w_next_state   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        end else if (r_state == S_FLUSH) begin
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_bubble   = 1'b1;
          if (r_fcnt != '0) w_next_fcnt = r_fcnt - 3'd1;
          w_next_state   = (r_fcnt <= 3'd1) ? S_RUN : S_FLUSH;
        end else begin
          // S_RUN, or the S_MWAIT cycle in which busy drops (evaluated as S_RUN)
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
          if (w_load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
          end
          w_next_state   = (r_fcnt != '0) ? S_FLUSH : S_RUN;
        end
      end
      default: begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        mem_wb_bubble = 1'b1;
        w_next_state  = S_RUN;
      end
    endcase
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  // Saturating performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if ((r_state != S_INIT) && !pc_write_en && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_redir_taken && (r_flush_events != '1))
        r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule
